// File: rtl/mil_txd_fifo.sv
// mil_txd_fifo: Manchester II (1553-style) word transmitter fed by a word FIFO.
// Each word goes out as 3-bit sync, DATA_W data bits MSB first, then odd parity.
module mil_txd_fifo #(
    parameter int DATA_W      = 16,
    parameter int CLK_PER_BIT = 50,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             dat,
    input  logic                          cw,
    input  logic                          wr_en,
    output logic                          wr_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          TXP,
    output logic                          TXN,
    output logic                          en_tx,
    output logic                          busy,
    output logic                          T_end
);
    localparam int H    = CLK_PER_BIT / 2;
    localparam int HW   = $clog2(H);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [HW-1:0]   H_LAST = HW'(H - 1);
    localparam logic [5:0]      D_LAST = 6'(2 * DATA_W - 1);
    localparam logic [CNTW-1:0] FULL   = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hc_q, hc_d;
    logic [5:0]        hi_q, hi_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              cw_q, cw_d, par_q, par_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              txp_q, txp_d, txn_q, txn_d, en_q, en_d, tend_q, tend_d;
    logic              push, pop, wrap, lvl;
    logic [DATA_W:0]   head;

    always_comb begin
        wrap  = hc_q == H_LAST;
        head  = mem_q[rp_q];
        // The next word is popped on the very edge that ends PAR, so words run back-to-back.
        pop   = cnt_q != '0 && (state_q == IDLE || (state_q == PAR && wrap && hi_q == 6'd1));
        push  = wr_en && cnt_q != FULL;
        mem_d = mem_q;
        if (push) mem_d[wp_q] = {cw, dat};
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
        state_d = state_q;
        hc_d    = hc_q;
        hi_d    = hi_q;
        sr_d    = sr_q;
        cw_d    = cw_q;
        par_d   = par_q;
        if (state_q != IDLE) begin
            hc_d = wrap ? '0 : hc_q + 1'b1;
            if (wrap) begin
                hi_d = hi_q + 1'b1;
                if (state_q == SYNC && hi_q == 6'd5) begin
                    state_d = DATA;
                    hi_d    = '0;
                end
                if (state_q == DATA) begin
                    if (hi_q[0]) sr_d = sr_q << 1;
                    if (hi_q == D_LAST) begin
                        state_d = PAR;
                        hi_d    = '0;
                    end
                end
                if (state_q == PAR && hi_q == 6'd1) state_d = IDLE;
            end
        end
        if (pop) begin
            state_d      = SYNC;
            hc_d         = '0;
            hi_d         = '0;
            {cw_d, sr_d} = head;
            par_d        = ~^head[DATA_W-1:0];
        end
        // Line levels are derived from next-state so the registered outputs line up with the FSM.
        lvl    = state_d == SYNC ? (hi_d < 6'd3 ? cw_d : ~cw_d)
               : state_d == DATA ? sr_d[DATA_W-1] ^ hi_d[0]
               : par_d ^ hi_d[0];
        en_d   = state_d != IDLE;
        txp_d  = en_d & lvl;
        txn_d  = en_d & ~lvl;
        tend_d = state_d == PAR && hi_d == 6'd1 && hc_d == H_LAST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hc_q    <= '0;
            hi_q    <= '0;
            sr_q    <= '0;
            cw_q    <= 1'b0;
            par_q   <= 1'b0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            txp_q   <= 1'b0;
            txn_q   <= 1'b0;
            en_q    <= 1'b0;
            tend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            hi_q    <= hi_d;
            sr_q    <= sr_d;
            cw_q    <= cw_d;
            par_q   <= par_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            txp_q   <= txp_d;
            txn_q   <= txn_d;
            en_q    <= en_d;
            tend_q  <= tend_d;
        end
    end

    assign wr_rdy   = cnt_q != FULL;
    assign fifo_cnt = cnt_q;
    assign TXP      = txp_q;
    assign TXN      = txn_q;
    assign en_tx    = en_q;
    assign T_end    = tend_q;
    assign busy     = en_q | (cnt_q != '0);
endmodule

// File: tb/tb_mil_txd_fifo.sv
// tb_mil_txd_fifo: scoreboard bench; stimulus queues expected words, monitors decode the line.
module tb_mil_txd_fifo;
    typedef struct {
        logic        c;
        logic [31:0] d;
        logic        p;
        logic        ct;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, cw, wr_rdy, TXP, TXN, en_tx, busy, T_end;
    logic [15:0] dat;
    logic [2:0]  fifo_cnt;
    logic        rst1, wr_en1, cw1, wr_rdy1, TXP1, TXN1, en_tx1, busy1, T_end1;
    logic [7:0]  dat1;
    logic [2:0]  fifo_cnt1;

    exp_t sb[$];
    exp_t sb1[$];
    int vecs = 0;
    int errs = 0;
    int nwords = 0;

    always #5 clk = ~clk;

    mil_txd_fifo u0 (.clk(clk), .rst(rst), .dat(dat), .cw(cw), .wr_en(wr_en), .wr_rdy(wr_rdy),
                     .fifo_cnt(fifo_cnt), .TXP(TXP), .TXN(TXN), .en_tx(en_tx), .busy(busy), .T_end(T_end));

    mil_txd_fifo #(.DATA_W(8), .CLK_PER_BIT(20), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst1), .dat(dat1), .cw(cw1), .wr_en(wr_en1), .wr_rdy(wr_rdy1),
        .fifo_cnt(fifo_cnt1), .TXP(TXP1), .TXN(TXN1), .en_tx(en_tx1), .busy(busy1), .T_end(T_end1));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        vecs++;
        if (a !== x) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    task automatic ex(input logic c, input logic [15:0] d, input logic p, input logic ct);
        exp_t e;
        e.c = c; e.d = 32'(d); e.p = p; e.ct = ct;
        sb.push_back(e);
    endtask

    task automatic wr(input logic c, input logic [15:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; cw = c; dat = d;
    endtask

    task automatic stop();
        @(posedge clk); #1;
        wr_en = 1'b0; cw = ~cw; dat = ~dat;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        #1;
    endtask

    // Monitor for the 16-bit / 50-clock instance: records one level per half-bit.
    initial begin : mon0
        logic       lv [40];
        logic [5:0] sy;
        logic [15:0] d;
        logic       p, ab;
        int         gap, bad, te, len;
        exp_t       e;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (rst) gap = 1000;
            else if (!en_tx) gap++;
            else begin
                ab = 0; bad = 0; te = 0; len = 0;
                for (int k = 0; k < 1000; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin ab = 1; break; end
                    if (!en_tx) break;
                    len++;
                    if (k % 25 == 0) lv[k/25] = TXP;
                    else if (TXP !== lv[k/25]) bad++;
                    if (TXN !== ~TXP) bad++;
                    if (T_end !== (k == 999)) te++;
                end
                if (ab) gap = 1000;
                else begin
                    chk("word length", len, 1000);
                    if (len == 1000) begin
                        for (int i = 0; i < 6; i++) sy[5-i] = lv[i];
                        for (int i = 0; i < 16; i++) begin
                            d[15-i] = lv[6+2*i];
                            if (lv[7+2*i] === lv[6+2*i]) bad++;
                        end
                        p = lv[38];
                        if (lv[39] === p) bad++;
                        nwords++;
                        if (sb.size() == 0) begin
                            vecs++; errs++;
                            $display("FAIL unexpected word: got %0h expected none at %0t", d, $time);
                        end else begin
                            e = sb.pop_front();
                            chk("sync", sy, e.c ? 6'b111000 : 6'b000111);
                            chk("data", d, e.d);
                            chk("parity", p, e.p);
                            chk("line glitches", bad, 0);
                            chk("T_end placement", te, 0);
                            if (e.ct) chk("inter-word gap", gap, 0);
                        end
                        gap = 0;
                    end else gap = 1;
                end
            end
        end
    end

    // Monitor for the 8-bit / 20-clock instance.
    initial begin : mon1
        logic       lv [24];
        logic [5:0] sy;
        logic [7:0] d;
        logic       p, ab;
        int         bad, te, len;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst1 && en_tx1) begin
                ab = 0; bad = 0; te = 0; len = 0;
                for (int k = 0; k < 240; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst1) begin ab = 1; break; end
                    if (!en_tx1) break;
                    len++;
                    if (k % 10 == 0) lv[k/10] = TXP1;
                    else if (TXP1 !== lv[k/10]) bad++;
                    if (TXN1 !== ~TXP1) bad++;
                    if (T_end1 !== (k == 239)) te++;
                end
                if (!ab) begin
                    chk("v word length", len, 240);
                    if (len == 240) begin
                        for (int i = 0; i < 6; i++) sy[5-i] = lv[i];
                        for (int i = 0; i < 8; i++) begin
                            d[7-i] = lv[6+2*i];
                            if (lv[7+2*i] === lv[6+2*i]) bad++;
                        end
                        p = lv[22];
                        if (lv[23] === p) bad++;
                        if (sb1.size() == 0) begin
                            vecs++; errs++;
                            $display("FAIL v unexpected word: got %0h expected none at %0t", d, $time);
                        end else begin
                            e = sb1.pop_front();
                            chk("v sync", sy, e.c ? 6'b111000 : 6'b000111);
                            chk("v data", d, e.d);
                            chk("v parity", p, e.p);
                            chk("v line glitches", bad, 0);
                            chk("v T_end placement", te, 0);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [2:0]  cnts [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [15:0] fd   [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        logic        fp   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t        e1;
        int          w0, hits, n;
        rst = 1; rst1 = 1; wr_en = 0; wr_en1 = 0; cw = 0; cw1 = 0; dat = '0; dat1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst TXP", TXP, 0);
        chk("rst TXN", TXN, 0);
        chk("rst en_tx", en_tx, 0);
        chk("rst busy", busy, 0);
        chk("rst T_end", T_end, 0);
        chk("rst fifo_cnt", fifo_cnt, 0);
        chk("rst wr_rdy", wr_rdy, 1);
        rst = 0; rst1 = 0;
        repeat (2) @(posedge clk);

        // Single command word 9ABC: nine ones, so parity 0.
        ex(1'b1, 16'h9ABC, 1'b0, 1'b0);
        wr(1'b1, 16'h9ABC);
        stop();
        chk("lat fifo_cnt", fifo_cnt, 1);
        chk("lat en_tx early", en_tx, 0);
        chk("lat busy", busy, 1);
        @(posedge clk); #1;
        chk("lat en_tx", en_tx, 1);
        chk("lat first sync", TXP, 1);
        chk("lat popped", fifo_cnt, 0);
        drain(1200);
        chk("single idle en_tx", en_tx, 0);
        chk("single idle TXP", TXP, 0);
        chk("single idle TXN", TXN, 0);
        chk("single idle busy", busy, 0);

        // Contiguous burst: CW 9ABC then DW 6523 (seven ones, parity 0).
        ex(1'b1, 16'h9ABC, 1'b0, 1'b0);
        ex(1'b0, 16'h6523, 1'b0, 1'b1);
        wr(1'b1, 16'h9ABC);
        wr(1'b0, 16'h6523);
        stop();
        drain(2300);
        chk("burst idle en_tx", en_tx, 0);

        // FIFO full: six writes, the sixth dropped.
        w0 = nwords;
        for (int i = 0; i < 5; i++) ex(i[0], fd[i], fp[i], i != 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i > 0) chk("fifo_cnt seq", fifo_cnt, cnts[i-1]);
            if (i == 5) chk("full wr_rdy", wr_rdy, 0);
            wr_en = 1'b1; cw = i[0]; dat = 16'(i + 1);
        end
        stop();
        chk("fifo_cnt seq", fifo_cnt, cnts[5]);
        drain(5500);
        chk("full busy after last", busy, 0);
        chk("full en_tx after last", en_tx, 0);
        repeat (100) @(posedge clk);
        #1;
        chk("full words sent", nwords - w0, 5);

        // Reset mid-word with two words queued.
        ex(1'b1, 16'h1111, 1'b1, 1'b0);
        wr(1'b1, 16'h1111);
        wr(1'b0, 16'h2222);
        wr(1'b1, 16'h3333);
        stop();
        chk("pre-reset fifo_cnt", fifo_cnt, 2);
        repeat (397) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async TXP", TXP, 0);
        chk("async TXN", TXN, 0);
        chk("async en_tx", en_tx, 0);
        chk("async fifo_cnt", fifo_cnt, 0);
        chk("async wr_rdy", wr_rdy, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hits = 0;
        repeat (1500) begin
            @(negedge clk);
            if (en_tx || busy || fifo_cnt != 0) hits++;
        end
        chk("post-reset silence", hits, 0);

        // Parity-1 case: all-zero data word.
        ex(1'b0, 16'h0000, 1'b1, 1'b0);
        wr(1'b0, 16'h0000);
        stop();
        drain(1200);
        chk("zero idle en_tx", en_tx, 0);

        // Variant instance: A5 has four ones, parity 1.
        e1.c = 1'b1; e1.d = 32'h0000_00A5; e1.p = 1'b1; e1.ct = 1'b0;
        sb1.push_back(e1);
        @(posedge clk); #1;
        wr_en1 = 1'b1; cw1 = 1'b1; dat1 = 8'hA5;
        @(posedge clk); #1;
        wr_en1 = 1'b0; cw1 = 1'b0; dat1 = 8'h00;
        chk("v wr_rdy", wr_rdy1, 1);
        @(posedge clk); #1;
        chk("v en_tx", en_tx1, 1);
        chk("v first sync", TXP1, 1);
        n = 0;
        while (sb1.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("v drain", sb1.size(), 0);
        #1;
        chk("v idle en_tx", en_tx1, 0);
        chk("v idle TXP", TXP1, 0);
        chk("v idle TXN", TXN1, 0);
        chk("v idle busy", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mil_txd_fifo.md
Name: mil_txd_fifo

Overview:
- Parametrised MIL-STD-1553-style Manchester II transmitter. Successor to the fixed 16-bit single-word transmitter.
- Accepts words of DATA_W bits, each with a sync-type flag, into an internal FIFO of FIFO_DEPTH entries.
- Transmits each word as sync + data + odd parity on a differential TXP/TXN pair.
- Queued words go out back-to-back with no inter-word gap. Sits between the host/controller logic and the bus line driver, in the same clock domain as the receiver.

Parameters:
- DATA_W, 16: data bits per word, range 4..32.
- CLK_PER_BIT, 50: clk cycles per bit time. Must be even and >= 4; default gives 1 Mbit/s at 50 MHz.
- FIFO_DEPTH, 4: word FIFO entries, power of two, range 2..16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- dat  in  DATA_W  word to queue
- cw  in  1  sync type: 1 = command/status sync, 0 = data sync
- wr_en  in  1  write request
- wr_rdy  out  1  FIFO not full; a write is accepted only when wr_en & wr_rdy
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupied entries
- TXP  out  1  positive line
- TXN  out  1  negative line
- en_tx  out  1  transmitter driving the line
- busy  out  1  word in progress or FIFO non-empty
- T_end  out  1  one-clock pulse on the last clock of each word

Behaviour:
- Reset (async, immediate):
  - TXP=0, TXN=0, en_tx=0, busy=0, T_end=0.
  - FIFO flushed, fifo_cnt=0, wr_rdy=1.
  - FSM returns to IDLE. A word in flight is truncated immediately, with no partial completion after release.
- Half-bit timing:
  - H = CLK_PER_BIT/2 clocks.
  - A half-bit counter runs 0..H-1, and a half-bit index steps at each wrap.
- Word format, in half-bit levels of TXP:
  - Sync, 6 half-bits: cw=1 gives H,H,H,L,L,L. cw=0 gives L,L,L,H,H,H.
  - Data, MSB first: 1 = H then L; 0 = L then H.
  - Parity bit: chosen so the total count of ones in data plus parity is odd. Encoded the same way as data.
  - Word length: (4+DATA_W)*CLK_PER_BIT clocks.
- Line outputs:
  - While en_tx=1, TXN = ~TXP every clock.
  - While en_tx=0, TXP=TXN=0 (bus idle).
  - All line outputs are registered.
- FSM states: IDLE, SYNC, DATA, PAR.
  - IDLE -> SYNC when the FIFO is non-empty. Pops the head, loads the shift register and parity.
  - SYNC -> DATA after 6 half-bits.
  - DATA -> PAR after 2*DATA_W half-bits.
  - PAR -> SYNC at word end if the FIFO is non-empty: pops the next word, contiguous with no idle clock. Otherwise PAR -> IDLE.
  - T_end=1 on the final clock of PAR in both cases.
- Latency: a word written at edge E into an empty FIFO while IDLE shows en_tx=1 and the first sync half-bit from edge E+1.
- FIFO rules:
  - Write and pop in the same edge are both honoured; fifo_cnt stays unchanged.
  - wr_rdy = (fifo_cnt != FIFO_DEPTH), computed from registered state. A write while full is dropped, with no overwrite and no count change, even if a pop occurs on that edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop is never issued when the FIFO is empty.
- busy = en_tx | (fifo_cnt != 0).
- dat and cw are sampled only on the accepting edge. Later changes do not affect queued words.

Test Plan:
- Single command word:
  - Stimulus: dat=16'h9ABC, cw=1, one-clock write.
  - Check en_tx high for exactly 1000 clocks.
  - Check TXP high for the first 75 clocks, then low 75.
  - Check data bits decode to 9ABC and the parity bit is 0 (nine ones).
  - Check one T_end pulse on clock 1000, then TXP=TXN=0.
- Contiguous burst:
  - Stimulus: CW 16'h9ABC (cw=1), then DW 16'h6523 (cw=0) on consecutive clocks.
  - Check en_tx continuous for 2000 clocks with no idle clock between words.
  - Check the second sync is low 75 then high 75, the second parity is 0, and T_end pulses at clocks 1000 and 2000.
- Parity-1 case:
  - Stimulus: dat=16'h0000, cw=0.
  - Check the data half-bits all read L,H and the parity bit is 1 (H,L).
- FIFO full:
  - Stimulus: 6 writes on consecutive clocks while idle, FIFO_DEPTH=4.
  - Check the first 5 are accepted (the first is popped immediately) and the 6th is dropped with wr_rdy=0.
  - Check fifo_cnt sequence 1,1,2,3,4,4, exactly 5 words transmitted, and busy deasserting after the 5th T_end.
- Reset mid-word:
  - Stimulus: assert rst at clock 400 of a word with 2 words queued.
  - Check TXP, TXN and en_tx go to 0 without waiting for a clock edge, and fifo_cnt=0.
  - After release, check no transmission occurs until a new write.
- Parameter variant:
  - Stimulus: DATA_W=8, CLK_PER_BIT=20, dat=8'hA5, cw=1.
  - Check a word length of 240 clocks, sync of 30 high then 30 low, data A5 MSB first, and parity 1 (four ones).
